input_buffer_route: RTL and testbench

- Per-port input stage of the 5-port mesh router. Instantiated once for each of N, E, W, S and L.
- Buffers incoming 17-bit flits in a small FIFO.
- Computes the XY route for each head flit and holds that route for the packet's body and tail flits (wormhole).
- Presents the front flit and a 6-bit direction vector to the output data logic. Returns one credit upstream per flit it consumes.

---
 rtl/input_buffer_route.sv | 137 +++++++++++++
 tb/tb_input_buffer_route.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/input_buffer_route.sv
// Per-port router input stage: flit FIFO, XY route computation and wormhole route hold.
// Optional protocol checking (err_o, discard of unroutable body flits) under BUF_PROTOCOL_CHK_EN.
module input_buffer_route #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned COORD_W = 3,
    parameter int unsigned X_COORD = 0,
    parameter int unsigned Y_COORD = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [16:0]              data_i,
    input  logic                     valid_i,
    input  logic                     read_i,
    output logic [16:0]              data_o,
    output logic [5:0]               dir_o,
    output logic                     credit_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
`ifdef BUF_PROTOCOL_CHK_EN
    ,
    output logic                     err_o
`endif
);

    localparam int unsigned FLIT_W = 17;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned DIR_W  = 6;

    localparam logic [DIR_W-1:0] DIR_STALL = 6'b100000;
    localparam logic [DIR_W-1:0] DIR_N     = 6'b010000;
    localparam logic [DIR_W-1:0] DIR_E     = 6'b001000;
    localparam logic [DIR_W-1:0] DIR_W_    = 6'b000100;
    localparam logic [DIR_W-1:0] DIR_S     = 6'b000010;
    localparam logic [DIR_W-1:0] DIR_L     = 6'b000001;

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count_q, count_nxt;
    logic              full_q;
    logic              credit_q;
    logic              route_vld;
    logic [DIR_W-1:0]  route_q;

    logic [FLIT_W-1:0]  front;
    logic [COORD_W-1:0] dst_x, dst_y;
    logic [DIR_W-1:0]   xy_dir;
    logic               empty, front_head, front_tail;
    logic               discard, pop, wr_en;

    // Front entry decode and XY route for a head flit
    always_comb begin
        front      = mem[rd_ptr];
        empty      = (count_q == '0);
        front_head = front[16];
        front_tail = front[15];
        dst_x      = front[14 -: COORD_W];
        dst_y      = front[14-COORD_W -: COORD_W];
        xy_dir     = DIR_L;
        if (dst_x > COORD_W'(X_COORD))      xy_dir = DIR_E;
        else if (dst_x < COORD_W'(X_COORD)) xy_dir = DIR_W_;
        else if (dst_y > COORD_W'(Y_COORD)) xy_dir = DIR_N;
        else if (dst_y < COORD_W'(Y_COORD)) xy_dir = DIR_S;
    end

    // Presented direction: head routes itself, body/tail follow the held route
    always_comb begin
        dir_o  = DIR_STALL;
        data_o = '0;
        if (!empty) begin
            data_o = front;
            if (front_head)     dir_o = xy_dir;
            else if (route_vld) dir_o = route_q;
        end
    end

    always_comb begin
`ifdef BUF_PROTOCOL_CHK_EN
        discard = !empty && !front_head && !route_vld;
`else
        discard = 1'b0;
`endif
        pop   = !empty && ((read_i && !dir_o[5]) || discard);
        wr_en = valid_i && (!full_q || pop);
        count_nxt = count_q;
        if (wr_en && !pop)      count_nxt = count_q + CNT_W'(1);
        else if (!wr_en && pop) count_nxt = count_q - CNT_W'(1);
    end

    // Storage is not reset; data_o masks it while empty
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            credit_q  <= 1'b0;
            route_vld <= 1'b0;
            route_q   <= DIR_STALL;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
            count_q  <= count_nxt;
            full_q   <= (count_nxt == CNT_W'(DEPTH));
            credit_q <= pop;
            if (pop && front_tail) begin
                route_vld <= 1'b0;
            end else if (pop && front_head) begin
                route_vld <= 1'b1;
                route_q   <= xy_dir;
            end
        end
    end

`ifdef BUF_PROTOCOL_CHK_EN
    logic err_q;

    // Sticky: dropped write, head arriving mid-packet, or discarded unroutable flit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_q || (valid_i && full_q && !pop)
                                   || (pop && front_head && route_vld)
                                   || discard;
    end

    assign err_o = err_q;
`endif

    assign credit_o = credit_q;
    assign full_o   = full_q;
    assign count_o  = count_q;

endmodule

// File: tb/tb_input_buffer_route.sv
// Directed bench for input_buffer_route at router position (1,1).
// Build with BUF_PROTOCOL_CHK_EN defined to also exercise err_o and discard behaviour.
module tb_input_buffer_route;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [16:0] data_i;
    logic        valid_i;
    logic        read_i;
    logic [16:0] data_o;
    logic [5:0]  dir_o;
    logic        credit_o;
    logic        full_o;
    logic [2:0]  count_o;
`ifdef BUF_PROTOCOL_CHK_EN
    logic        err_o;
`endif

    int tests = 0;
    int fails = 0;

    input_buffer_route #(.DEPTH(4), .COORD_W(3), .X_COORD(1), .Y_COORD(1)) dut (
        .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i), .read_i(read_i),
        .data_o(data_o), .dir_o(dir_o), .credit_o(credit_o), .full_o(full_o), .count_o(count_o)
`ifdef BUF_PROTOCOL_CHK_EN
        , .err_o(err_o)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] mk(bit h, bit t, logic [2:0] x, logic [2:0] y, logic [8:0] pl);
        return {h, t, x, y, pl};
    endfunction

    // One clock with the given inputs; returns 1ns after the edge
    task automatic cyc(input bit v, input logic [16:0] d, input bit r);
        valid_i = v; data_i = d; read_i = r;
        @(posedge clk); #1;
        valid_i = 1'b0; data_i = '0; read_i = 1'b0;
    endtask

    task automatic do_reset();
        valid_i = 1'b0; data_i = '0; read_i = 1'b0;
        rst_n = 1'b0; #1;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        cyc(1, 17'h1_4000, 0);
        cyc(1, mk(0, 0, 3'd5, 3'd5, 9'h1f), 0);
        cyc(0, '0, 1);
        tests++; if (credit_o !== 1'b1) begin fails++; $display("FAIL reset_pre_credit got %b exp 1", credit_o); end
        rst_n = 1'b0; #1;
        tests++; if (data_o !== 17'h0) begin fails++; $display("FAIL reset_data got %h exp 0", data_o); end
        tests++; if (dir_o !== 6'b100000) begin fails++; $display("FAIL reset_dir got %b exp 100000", dir_o); end
        tests++; if (count_o !== 3'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", count_o); end
        tests++; if (full_o !== 1'b0) begin fails++; $display("FAIL reset_full got %b exp 0", full_o); end
        tests++; if (credit_o !== 1'b0) begin fails++; $display("FAIL reset_credit got %b exp 0", credit_o); end
`ifdef BUF_PROTOCOL_CHK_EN
        tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL reset_err got %b exp 0", err_o); end
`endif
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_route_east();
        do_reset();
        cyc(1, 17'h1_4000, 0);
        tests++; if (dir_o !== 6'b001000) begin fails++; $display("FAIL east_dir got %b exp 001000", dir_o); end
        tests++; if (data_o !== 17'h1_4000) begin fails++; $display("FAIL east_data got %h exp 14000", data_o); end
        tests++; if (count_o !== 3'd1) begin fails++; $display("FAIL east_count got %0d exp 1", count_o); end
    endtask

    task automatic test_packet();
        logic [16:0] pk [4];
        do_reset();
        pk[0] = mk(1, 0, 3'd1, 3'd3, 9'h011);
        pk[1] = {2'b00, 15'h7abc};
        pk[2] = {2'b00, 15'h0123};
        pk[3] = {2'b01, 15'h5a5a};
        for (int i = 0; i < 4; i++) cyc(1, pk[i], 0);
        for (int i = 0; i < 4; i++) begin
            tests++; if (data_o !== pk[i]) begin fails++; $display("FAIL pkt_data%0d got %h exp %h", i, data_o, pk[i]); end
            tests++; if (dir_o !== 6'b010000) begin fails++; $display("FAIL pkt_dir%0d got %b exp 010000", i, dir_o); end
            cyc(0, '0, 1);
            tests++; if (credit_o !== 1'b1) begin fails++; $display("FAIL pkt_credit%0d got %b exp 1", i, credit_o); end
        end
        cyc(0, '0, 0);
        tests++; if (credit_o !== 1'b0) begin fails++; $display("FAIL pkt_credit_end got %b exp 0", credit_o); end
        cyc(1, {2'b00, 15'h1111}, 0);
        tests++; if (dir_o !== 6'b100000) begin fails++; $display("FAIL pkt_route_cleared got %b exp 100000", dir_o); end
        tests++; if (count_o !== 3'd1) begin fails++; $display("FAIL pkt_count_after got %0d exp 1", count_o); end
`ifdef BUF_PROTOCOL_CHK_EN
        tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL pkt_err got %b exp 0", err_o); end
`endif
    endtask

    task automatic test_full_wrap();
        logic [16:0] f [5];
        logic [5:0]  fd [5];
        do_reset();
        f[0] = mk(1, 1, 3'd0, 3'd5, 9'h100); fd[0] = 6'b000100;
        f[1] = mk(1, 1, 3'd3, 3'd0, 9'h101); fd[1] = 6'b001000;
        f[2] = mk(1, 1, 3'd1, 3'd0, 9'h102); fd[2] = 6'b000010;
        f[3] = mk(1, 1, 3'd1, 3'd1, 9'h103); fd[3] = 6'b000001;
        f[4] = mk(1, 1, 3'd1, 3'd7, 9'h104); fd[4] = 6'b010000;
        for (int i = 0; i < 4; i++) cyc(1, f[i], 0);
        tests++; if (full_o !== 1'b1) begin fails++; $display("FAIL full_flag got %b exp 1", full_o); end
        tests++; if (count_o !== 3'd4) begin fails++; $display("FAIL full_count got %0d exp 4", count_o); end
        cyc(1, mk(1, 1, 3'd6, 3'd6, 9'h1ee), 0);
        tests++; if (count_o !== 3'd4) begin fails++; $display("FAIL drop_count got %0d exp 4", count_o); end
`ifdef BUF_PROTOCOL_CHK_EN
        tests++; if (err_o !== 1'b1) begin fails++; $display("FAIL drop_err got %b exp 1", err_o); end
`endif
        tests++; if (dir_o !== fd[0]) begin fails++; $display("FAIL wrap_dir0 got %b exp %b", dir_o, fd[0]); end
        cyc(1, f[4], 1);
        tests++; if (count_o !== 3'd4) begin fails++; $display("FAIL wrap_count got %0d exp 4", count_o); end
        tests++; if (full_o !== 1'b1) begin fails++; $display("FAIL wrap_full got %b exp 1", full_o); end
        tests++; if (credit_o !== 1'b1) begin fails++; $display("FAIL wrap_credit got %b exp 1", credit_o); end
        for (int i = 1; i < 5; i++) begin
            tests++; if (data_o !== f[i]) begin fails++; $display("FAIL wrap_data%0d got %h exp %h", i, data_o, f[i]); end
            tests++; if (dir_o !== fd[i]) begin fails++; $display("FAIL wrap_dir%0d got %b exp %b", i, dir_o, fd[i]); end
            cyc(0, '0, 1);
        end
        tests++; if (count_o !== 3'd0) begin fails++; $display("FAIL wrap_drained got %0d exp 0", count_o); end
        tests++; if (full_o !== 1'b0) begin fails++; $display("FAIL wrap_notfull got %b exp 0", full_o); end
    endtask

    task automatic test_local_stall();
        logic [16:0] ht;
        do_reset();
        ht = mk(1, 1, 3'd1, 3'd1, 9'h0aa);
        cyc(1, ht, 0);
        cyc(1, {2'b00, 15'h2222}, 0);
        tests++; if (dir_o !== 6'b000001) begin fails++; $display("FAIL local_dir got %b exp 000001", dir_o); end
        tests++; if (data_o !== ht) begin fails++; $display("FAIL local_data got %h exp %h", data_o, ht); end
        cyc(0, '0, 1);
        tests++; if (dir_o !== 6'b100000) begin fails++; $display("FAIL stall_dir got %b exp 100000", dir_o); end
        tests++; if (count_o !== 3'd1) begin fails++; $display("FAIL stall_count got %0d exp 1", count_o); end
        cyc(0, '0, 1);
`ifdef BUF_PROTOCOL_CHK_EN
        tests++; if (count_o !== 3'd0) begin fails++; $display("FAIL discard_count got %0d exp 0", count_o); end
        tests++; if (credit_o !== 1'b1) begin fails++; $display("FAIL discard_credit got %b exp 1", credit_o); end
        tests++; if (err_o !== 1'b1) begin fails++; $display("FAIL discard_err got %b exp 1", err_o); end
`else
        tests++; if (count_o !== 3'd1) begin fails++; $display("FAIL stall_hold_count got %0d exp 1", count_o); end
        tests++; if (credit_o !== 1'b0) begin fails++; $display("FAIL stall_credit got %b exp 0", credit_o); end
        cyc(0, '0, 1);
        tests++; if (dir_o !== 6'b100000) begin fails++; $display("FAIL stall_dir2 got %b exp 100000", dir_o); end
`endif
    endtask

    task automatic test_empty_read();
        logic [16:0] fl;
        do_reset();
        cyc(0, '0, 1);
        tests++; if (count_o !== 3'd0) begin fails++; $display("FAIL empty_count got %0d exp 0", count_o); end
        tests++; if (credit_o !== 1'b0) begin fails++; $display("FAIL empty_credit got %b exp 0", credit_o); end
        tests++; if (data_o !== 17'h0) begin fails++; $display("FAIL empty_data got %h exp 0", data_o); end
        cyc(0, '0, 1);
        tests++; if (credit_o !== 1'b0) begin fails++; $display("FAIL empty_credit2 got %b exp 0", credit_o); end
        fl = mk(1, 1, 3'd0, 3'd1, 9'h033);
        cyc(1, fl, 0);
        tests++; if (data_o !== fl) begin fails++; $display("FAIL empty_then_data got %h exp %h", data_o, fl); end
        tests++; if (dir_o !== 6'b000100) begin fails++; $display("FAIL empty_then_dir got %b exp 000100", dir_o); end
        tests++; if (count_o !== 3'd1) begin fails++; $display("FAIL empty_then_count got %0d exp 1", count_o); end
    endtask

    initial begin
        rst_n = 1'b0; valid_i = 1'b0; read_i = 1'b0; data_i = '0;
        repeat (2) @(posedge clk);
        test_reset();
        test_route_east();
        test_packet();
        test_full_wrap();
        test_local_stall();
        test_empty_read();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
